// File: rtl/btb_write.sv
// rtl/btb_write.sv - 2-way, 8-set BTB storage: combinational read port, EX-side update, per-set LRU.
module btb_write (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [2:0]   read_index,
    output logic [127:0] read_set,
    output logic [7:0]   LRU,
    input  logic         read_en,
    input  logic         next_LRU_read,
    input  logic         update_en,
    input  logic [31:0]  update_pc,
    input  logic [31:0]  update_target,
    input  logic         update_taken
);

    localparam logic [1:0] ST_WT = 2'b11;

    logic [127:0] sets_q [8];
    logic [127:0] sets_d [8];
    logic [7:0]   lru_q;
    logic [7:0]   lru_d;

    logic [2:0]   upd_idx;
    logic [26:0]  upd_tag;
    logic [63:0]  way1, way2, hit_entry, new_entry;
    logic         hit1, hit2, hit, alloc_way, wr_way, wr_en;
    logic [1:0]   nxt_state;

    function automatic logic [1:0] next_state(input logic [1:0] s, input logic taken);
        logic [1:0] n;
        if (taken) n = (s == 2'b00) ? 2'b01 : 2'b10;
        else       n = (s == 2'b10) ? 2'b11 : 2'b00;
        return n;
    endfunction

    assign read_set = sets_q[read_index];
    assign LRU      = lru_q;

    assign upd_idx   = update_pc[4:2];
    assign upd_tag   = update_pc[31:5];
    assign way1      = sets_q[upd_idx][127:64];
    assign way2      = sets_q[upd_idx][63:0];
    assign hit1      = way1[63] && (way1[62:36] == upd_tag);
    assign hit2      = way2[63] && (way2[62:36] == upd_tag);
    assign hit       = hit1 || hit2;
    assign hit_entry = hit1 ? way1 : way2;
    assign nxt_state = next_state(hit_entry[3:2], update_taken);

    // Fill an invalid way first; once both are valid, evict the way not used most recently.
    assign alloc_way = !way1[63] ? 1'b0 : (!way2[63] ? 1'b1 : ~lru_q[upd_idx]);
    assign wr_way    = hit ? ~hit1 : alloc_way;
    assign wr_en     = update_en && (hit || update_taken);

    always_comb begin
        new_entry = '0;
        if (hit) begin
            new_entry = {1'b1, upd_tag,
                         update_taken ? update_target : hit_entry[35:4],
                         nxt_state, 2'b00};
        end else begin
            new_entry = {1'b1, upd_tag, update_target, ST_WT, 2'b00};
        end
    end

    always_comb begin
        for (int i = 0; i < 8; i++) sets_d[i] = sets_q[i];
        lru_d = lru_q;
        if (read_en) lru_d[read_index] = next_LRU_read;
        // The EX update belongs to the older instruction, so it overrides the IF LRU write.
        if (wr_en) begin
            lru_d[upd_idx] = wr_way;
            if (wr_way) sets_d[upd_idx][63:0]   = new_entry;
            else        sets_d[upd_idx][127:64] = new_entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) sets_q[i] <= '0;
            lru_q <= '0;
        end else begin
            for (int i = 0; i < 8; i++) sets_q[i] <= sets_d[i];
            lru_q <= lru_d;
        end
    end

endmodule

// File: tb/tb_btb_write.sv
// tb/tb_btb_write.sv - directed table-driven bench for btb_write.
module tb_btb_write;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [2:0]   read_index;
    logic [127:0] read_set;
    logic [7:0]   LRU;
    logic         read_en, next_LRU_read, update_en, update_taken;
    logic [31:0]  update_pc, update_target;

    int n_vec = 0;
    int n_bad = 0;

    btb_write dut (
        .clk(clk), .rst_n(rst_n), .read_index(read_index), .read_set(read_set),
        .LRU(LRU), .read_en(read_en), .next_LRU_read(next_LRU_read),
        .update_en(update_en), .update_pc(update_pc), .update_target(update_target),
        .update_taken(update_taken)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         ue;
        logic [31:0]  pc;
        logic [31:0]  tgt;
        logic         tk;
        logic         re;
        logic [2:0]   ri;
        logic         nl;
        logic [2:0]   ci;
        logic [127:0] es;
        logic [7:0]   el;
    } vec_t;

    function automatic logic [63:0] ent(input logic [26:0] tag, input logic [31:0] tgt,
                                        input logic [1:0] st);
        return {1'b1, tag, tgt, st, 2'b00};
    endfunction

    function automatic vec_t mk(input logic ue, input logic [31:0] pc, input logic [31:0] tgt,
                                input logic tk, input logic re, input logic [2:0] ri,
                                input logic nl, input logic [2:0] ci,
                                input logic [127:0] es, input logic [7:0] el);
        vec_t v;
        v.ue = ue; v.pc = pc; v.tgt = tgt; v.tk = tk; v.re = re; v.ri = ri;
        v.nl = nl; v.ci = ci; v.es = es; v.el = el;
        return v;
    endfunction

    task automatic check_set(input string name, input logic [127:0] exp);
        n_vec++;
        if (read_set !== exp) begin
            n_bad++;
            $display("FAIL %s: read_set[%0d] got %h want %h", name, read_index, read_set, exp);
        end
    endtask

    task automatic check_lru(input string name, input logic [7:0] exp);
        n_vec++;
        if (LRU !== exp) begin
            n_bad++;
            $display("FAIL %s: LRU got %h want %h", name, LRU, exp);
        end
    endtask

    task automatic idle_inputs();
        update_en = 1'b0; read_en = 1'b0; next_LRU_read = 1'b0;
        update_taken = 1'b0; update_pc = '0; update_target = '0;
    endtask

    vec_t vecs[15];

    initial begin
        logic [63:0] s2b1, s2b2;
        rst_n = 1'b1;
        read_index = '0;
        idle_inputs();

        // Initial async reset, released away from the clock edge.
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_lru("reset_lru", 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        vecs[0]  = mk(1, 32'h48, 32'h100, 1, 0, 0, 0, 2,
                      {ent(27'h2, 32'h100, 2'b11), 64'h0}, 8'h00);
        vecs[1]  = mk(1, 32'h48, 32'h100, 1, 0, 0, 0, 2,
                      {ent(27'h2, 32'h100, 2'b10), 64'h0}, 8'h00);
        vecs[2]  = mk(1, 32'h48, 32'h100, 1, 0, 0, 0, 2,
                      {ent(27'h2, 32'h100, 2'b10), 64'h0}, 8'h00);
        vecs[3]  = mk(1, 32'h48, 32'h999, 0, 0, 0, 0, 2,
                      {ent(27'h2, 32'h100, 2'b11), 64'h0}, 8'h00);
        vecs[4]  = mk(1, 32'h48, 32'h999, 0, 0, 0, 0, 2,
                      {ent(27'h2, 32'h100, 2'b00), 64'h0}, 8'h00);
        vecs[5]  = mk(1, 32'h48, 32'h999, 0, 0, 0, 0, 2,
                      {ent(27'h2, 32'h100, 2'b00), 64'h0}, 8'h00);
        vecs[6]  = mk(1, 32'h4C, 32'h500, 0, 0, 0, 0, 3, 128'h0, 8'h00);
        vecs[7]  = mk(1, 32'h68, 32'h200, 1, 0, 0, 0, 2,
                      {ent(27'h2, 32'h100, 2'b00), ent(27'h3, 32'h200, 2'b11)}, 8'h04);
        vecs[8]  = mk(1, 32'h88, 32'h300, 1, 0, 0, 0, 2,
                      {ent(27'h4, 32'h300, 2'b11), ent(27'h3, 32'h200, 2'b11)}, 8'h00);
        vecs[9]  = mk(1, 32'h68, 32'h204, 1, 0, 0, 0, 2,
                      {ent(27'h4, 32'h300, 2'b11), ent(27'h3, 32'h204, 2'b10)}, 8'h04);
        vecs[10] = mk(1, 32'h88, 32'h777, 0, 1, 2, 1, 2,
                      {ent(27'h4, 32'h300, 2'b00), ent(27'h3, 32'h204, 2'b10)}, 8'h00);
        vecs[11] = mk(1, 32'h88, 32'h304, 1, 1, 5, 1, 2,
                      {ent(27'h4, 32'h304, 2'b01), ent(27'h3, 32'h204, 2'b10)}, 8'h20);
        vecs[12] = mk(0, 32'h0, 32'h0, 0, 1, 5, 0, 2,
                      {ent(27'h4, 32'h304, 2'b01), ent(27'h3, 32'h204, 2'b10)}, 8'h00);
        vecs[13] = mk(0, 32'h48, 32'h111, 1, 0, 0, 0, 2,
                      {ent(27'h4, 32'h304, 2'b01), ent(27'h3, 32'h204, 2'b10)}, 8'h00);
        vecs[14] = mk(1, 32'hA8, 32'h400, 1, 0, 0, 0, 2,
                      {ent(27'h4, 32'h304, 2'b01), ent(27'h5, 32'h400, 2'b11)}, 8'h04);

        #1;
        for (int i = 0; i < 15; i++) begin
            update_en = vecs[i].ue; update_pc = vecs[i].pc; update_target = vecs[i].tgt;
            update_taken = vecs[i].tk; read_en = vecs[i].re; read_index = vecs[i].ri;
            next_LRU_read = vecs[i].nl;
            @(posedge clk);
            @(negedge clk);
            idle_inputs();
            read_index = vecs[i].ci;
            #1;
            check_set($sformatf("vec%0d_set", i), vecs[i].es);
            check_lru($sformatf("vec%0d_lru", i), vecs[i].el);
        end

        // Same-cycle read of the set being updated shows the old contents.
        s2b1 = ent(27'h4, 32'h304, 2'b01);
        s2b2 = ent(27'h5, 32'h400, 2'b11);
        read_index = 3'd2;
        update_en = 1'b1; update_pc = 32'hA8; update_target = 32'h404; update_taken = 1'b1;
        #1;
        check_set("no_bypass_pre", {s2b1, s2b2});
        @(posedge clk);
        #1;
        check_set("no_bypass_post", {s2b1, ent(27'h5, 32'h404, 2'b10)});
        @(negedge clk);

        // Reset asserted with an update pending: everything clears without a clock edge.
        update_en = 1'b1; update_pc = 32'h4C; update_target = 32'h600; update_taken = 1'b1;
        #2 rst_n = 1'b0;
        for (int i = 0; i < 8; i++) begin
            read_index = 3'(i);
            #0.5;
            check_set($sformatf("async_reset_set%0d", i), 128'h0);
        end
        check_lru("async_reset_lru", 8'h00);
        @(posedge clk);
        #1;
        read_index = 3'd3;
        #1;
        check_set("reset_discards_update", 128'h0);
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_set("post_reset_idle", 128'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/btb_write.md
Name: btb_write

Overview:
- Storage and update (write) side of the 2-way, 8-set branch target buffer.
- Holds the set array and per-set LRU bits, and presents the indexed set combinationally to the IF-stage BTB lookup.
- Commits resolved-branch outcomes from EX: allocation, target refresh, and 2-bit predictor state transitions.
- Also records the LRU value returned by the IF lookup.

Parameters:
- None. Geometry fixed: 8 sets, 2 ways, 27-bit tag, 3-bit index.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- read_index  in  3  IF lookup set index (PC[4:2])
- read_set  out  128  stored set at read_index; Branch1 = [127:64], Branch2 = [63:0]
- LRU  out  8  per-set LRU bits
- read_en  in  1  IF lookup accepted (pipeline not stalled)
- next_LRU_read  in  1  LRU value computed by the IF lookup for read_index
- update_en  in  1  EX resolved a branch this cycle
- update_pc  in  32  PC of resolved branch
- update_target  in  32  resolved branch target
- update_taken  in  1  resolved direction

Behaviour:
- Reset (async, rst_n=0):
  - All 128-bit sets cleared (valid=0, all fields 0); LRU = 8'h00; read_set reads 0.
  - Reset asserted mid-update discards that update.
- Entry format (64 bits): valid[63], tag[62:36], target[35:4], state[3:2], pad[1:0].
  - pad is always written 2'b00.
- Read path:
  - read_set = set[read_index], purely combinational.
  - Writes become visible the cycle after the clock edge; no same-cycle bypass.
- LRU meaning: LRU[i] records the most recently used way. 0 = Branch1 used last, so victim is Branch2; 1 = Branch2 used last, so victim is Branch1.
- IF LRU write: when read_en=1, LRU[read_index] <= next_LRU_read at the clock edge.
- Update decode: idx = update_pc[4:2]; tag = update_pc[31:5]. Hit way = valid && tag match; Branch1 wins if both ways match.
- Update with update_en=1, all writes at the clock edge:
  - Hit:
    - state <= next_state(state, update_taken).
    - If taken, target <= update_target; if not taken, target is unchanged.
    - LRU[idx] <= hit way (0 = Branch1, 1 = Branch2).
  - Miss and taken: allocate.
    - Way choice: Branch1 if invalid; else Branch2 if invalid; else the victim per LRU[idx].
    - Written entry: valid=1, tag, target = update_target, state = 2'b11 (WEAK_TAKEN).
    - LRU[idx] <= allocated way.
  - Miss and not taken: no write of any kind.
- Predictor transitions (SNT=00, WNT=01, ST=10, WT=11):
  - Taken: 00->01, 01->10, 10->10, 11->10.
  - Not taken: 00->00, 01->00, 10->11, 11->00.
  - Saturates at ST and SNT.
- Simultaneous events:
  - read_en and update_en targeting the same LRU index: the update write wins (older instruction).
  - Different indices: both writes occur.
  - Update and read on the same index in the same cycle: read_set shows the pre-update contents.
- update_en=0: set array unchanged.

Test Plan:
- Reset: drive rst_n=0 asynchronously mid-cycle -> LRU=8'h00 and read_set=128'h0 for every read_index 0..7, without waiting for a clock edge.
- Allocate: update_pc=0x00000048, target=0x00000100, taken=1 -> next cycle, read_index=2 gives read_set[127:64] = {1'b1, 27'h2, 32'h100, 2'b11, 2'b00}, Branch2 still 0, LRU[2]=0.
- Predictor walk: repeat the update at 0x48 with taken = 1,1,0,0,0 -> Branch1 state sequence 10, 10, 11, 00, 00. Target stays 0x100 after the not-taken updates.
- Replacement, set 2:
  - Allocate 0x48, then allocate 0x68 -> 0x68 goes to Branch2 (Branch2 invalid); LRU[2]=1.
  - Allocate 0x88 -> replaces Branch1 (victim per LRU[2]=1); LRU[2]=0.
- Miss, not taken: update_pc=0x0000004C, taken=0 -> set 3 and LRU unchanged.
- Collision: read_en=1, read_index=2, next_LRU_read=1 in the same cycle as a hit update on Branch1 of set 2 -> LRU[2]=0. The same case with read_index=5 -> LRU[5]=1 and LRU[2]=0.
